fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction-fetch front end of the rv32 five-stage pipeline. It sits directly upstream of decode: it drives the instruction memory through a req/ack handshake and buffers fetched words with their PCs in a small prefetch FIFO. It presents one instruction per cycle to decode, honours the hazard-unit stall, and flushes on a taken branch or jump redirect from execute.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request (registered level).
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1.
- imem_ack  in  1  transfer completes in any cycle with imem_req=1 and imem_ack=1.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- redirect  in  1  taken branch/jump from execute (pc_sel).
- redirect_pc  in  32  redirect target (ALU out); bits [1:0] are ignored and forced to 0.
- stall  in  1  hazard stall; decode does not consume this cycle.
- instr_valid  out  1  FIFO head valid.
- instr_fetch  out  32  head instruction; 32'h0000_0013 (NOP) when empty.
- pc  out  32  head PC; 0 when empty.
- pc_nxt  out  32  pc+4, modulo 2^32.

## Operation
- Internal state: fetch_pc (32), FIFO of {pc, instr} with DEPTH entries, count (0..DEPTH), FSM state.
- The FSM has three states:
  - IDLE: imem_req=0.
  - REQ: imem_req=1 with imem_addr=fetch_pc; the returned data is kept.
  - FLUSH: imem_req=1 with the old address held; the returned data is discarded.
- Credit rule: a new request may be outstanding only if count_next < DEPTH. Because of this, an enqueue never hits a full FIFO.
- IDLE transitions:
  - To REQ when count_next < DEPTH.
  - Stays in IDLE otherwise.
- REQ with ack and no redirect:
  - Enqueue {fetch_pc, imem_rdata}; fetch_pc += 4 (wraps 0xFFFF_FFFC→0).
  - Next state is REQ if count_next < DEPTH, else IDLE.
- REQ, no ack: hold.
- Redirect behaviour (takes priority over stall, enqueue and dequeue):
  - FIFO is cleared at the edge; count becomes 0; fetch_pc ← redirect_pc.
  - From IDLE, or from REQ/FLUSH with ack in the same cycle: next state is REQ at the new fetch_pc, and any acked data is dropped.
  - From REQ without ack: go to FLUSH. imem_addr stays at the old address, because a request cannot be aborted.
  - From FLUSH without ack: stay in FLUSH; fetch_pc takes the newest redirect_pc.
- FLUSH with ack and no redirect: discard the data; next state is REQ at fetch_pc.
- Dequeue occurs when instr_valid && !stall && !redirect, and can coincide with an enqueue.
- count_next = count + enqueue − dequeue, or 0 on redirect.
- Outputs are combinational from the FIFO head; instr_valid = (count != 0).
- Reset values: imem_req=0, imem_addr=RESET_PC, state IDLE, fetch_pc=RESET_PC, count=0, instr_valid=0, instr_fetch=NOP, pc=0, pc_nxt=4.
- rst overrides every other input.

## Timing
- Cycle 0 is the first cycle after rst deasserts. imem_req=1 in cycle 1 at RESET_PC.
- With a zero-wait ack in cycle 1, instr_valid=1 in cycle 2.
- Redirect sampled at the end of cycle N:
  - instr_valid=0 in N+1.
  - If no request is stuck in FLUSH, imem_req/imem_addr=redirect_pc in N+1.
  - The first new instruction is valid in N+2 at the earliest.
- If a request is stuck in FLUSH: one extra cycle after the old ack before the new request issues.
- Steady state with ack every cycle and no stall: one instruction per cycle, no bubbles.
- Stall holds head, pc and instr unchanged. Fetching continues until count reaches DEPTH, after which imem_req drops.
- imem_addr and imem_req change only on clock edges.

## Test plan
- Reset then ack every cycle, RESET_PC=0, imem_rdata=0x100+addr: expect pc 0,4,8,12 on consecutive cycles from cycle 2, with instr_fetch=0x100,0x104,…
- Stall held for 8 cycles with ack always high: head frozen at the same pc; imem_req deasserts once count=4; after release, 4 buffered instructions emerge back-to-back with no gap.
- Ack delayed 3 cycles: imem_addr stable throughout; instr_valid low until the ack; pc sequence correct.
- Redirect to 0x200 while 3 entries are buffered and a request is pending without ack:
  - FIFO is empty the next cycle and imem_addr stays at the old value until ack.
  - The old data is dropped, then a request to 0x200 issues and pc=0x200 is presented.
- Redirect and ack in the same cycle, with redirect_pc=0x203: the acked data is discarded and the next imem_addr=0x200. Also: fetch_pc at 0xFFFF_FFFC wraps to 0, and pc_nxt=0 when the head pc=0xFFFF_FFFC.
- rst asserted mid-FLUSH: all outputs at reset values next cycle; a subsequent fetch from RESET_PC proceeds normally.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - rv32 instruction-fetch front end with prefetch FIFO
//
// Purpose: issues word fetches to instruction memory over a req/ack handshake,
// buffers {pc, instr} pairs in a DEPTH-entry FIFO and presents the head to
// decode. It honours the hazard stall and flushes on an execute redirect.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   imem_req/addr      registered fetch request level and word address
//   imem_ack/rdata     transfer completion and returned instruction word
//   redirect/_pc       taken branch/jump and its target (low bits forced to 0)
//   stall              decode does not consume the head this cycle
//   instr_valid        FIFO head valid
//   instr_fetch, pc    head instruction (NOP when empty) and its PC (0 when empty)
//   pc_nxt             pc + 4
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr_fetch,
  output logic [31:0] pc,
  output logic [31:0] pc_nxt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FLUSH} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     addr_q, addr_d;
  logic            req_q, req_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [31:0]     pc_mem  [DEPTH];
  logic [31:0]     ins_mem [DEPTH];

  logic            acked, enq, deq, credit, new_req;
  logic [31:0]     target;

  assign instr_valid = (count_q != '0);
  assign instr_fetch = instr_valid ? ins_mem[rd_q] : NOP;
  assign pc          = instr_valid ? pc_mem[rd_q] : 32'h0;
  assign pc_nxt      = pc + 32'd4;
  assign imem_req    = req_q;
  assign imem_addr   = addr_q;

  always_comb begin
    target   = redirect_pc & ~32'h3;
    acked    = req_q & imem_ack;
    // Data returned while in FLUSH belongs to the pre-redirect stream.
    enq      = (state_q == S_REQ) & acked & ~redirect;
    deq      = instr_valid & ~stall & ~redirect;
    count_d  = redirect ? '0 : (count_q + CW'(enq) - CW'(deq));
    rd_d     = redirect ? '0 : (rd_q + AW'(deq));
    wr_d     = redirect ? '0 : (wr_q + AW'(enq));
    // A request is only issued when the slot its data needs is guaranteed.
    credit   = (count_d < CW'(DEPTH));

    fetch_pc_d = fetch_pc_q;
    if (redirect)  fetch_pc_d = target;
    else if (enq)  fetch_pc_d = fetch_pc_q + 32'd4;

    state_d = state_q;
    if (redirect) begin
      // An un-acked request cannot be withdrawn, so wait it out in FLUSH.
      state_d = ((state_q == S_IDLE) || acked) ? S_REQ : S_FLUSH;
    end else begin
      case (state_q)
        S_IDLE:  state_d = credit ? S_REQ : S_IDLE;
        S_REQ:   state_d = acked ? (credit ? S_REQ : S_IDLE) : S_REQ;
        S_FLUSH: state_d = acked ? S_REQ : S_FLUSH;
        default: state_d = S_IDLE;
      endcase
    end

    // A fresh address is launched only when the previous request is done.
    new_req = (state_d == S_REQ) && ((state_q != S_REQ) || acked);
    addr_d  = new_req ? fetch_pc_d : addr_q;
    req_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  // Storage needs no reset: entries are only observed while count is nonzero.
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      pc_mem[wr_q]  <= fetch_pc_q;
      ins_mem[wr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed table-driven bench for fetch_queue
module tb_fetch_queue;

  localparam logic [31:0] N = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_ack, redirect, stall, instr_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr_fetch, pc, pc_nxt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word at address A holds 0x100 + A.
  assign imem_rdata = imem_addr + 32'h100;

  fetch_queue #(.RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .instr_valid(instr_valid), .instr_fetch(instr_fetch),
    .pc(pc), .pc_nxt(pc_nxt)
  );

  typedef struct {
    logic        rst, ack, redir, stall;
    logic [31:0] rpc;
    logic        chk, req, ca;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ins, pcv;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, a, rd, st, input logic [31:0] rpc,
                     input logic c, rq, ca, input logic [31:0] ad,
                     input logic v, input logic [31:0] ins, pcv);
    vec_t e;
    e.rst = r; e.ack = a; e.redir = rd; e.stall = st; e.rpc = rpc;
    e.chk = c; e.req = rq; e.ca = ca; e.addr = ad; e.vld = v;
    e.ins = ins; e.pcv = pcv;
    vt.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_row(input int i);
    chk($sformatf("row%0d imem_req", i), {31'b0, imem_req}, {31'b0, vt[i].req});
    if (vt[i].ca) chk($sformatf("row%0d imem_addr", i), imem_addr, vt[i].addr);
    chk($sformatf("row%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, vt[i].vld});
    chk($sformatf("row%0d instr_fetch", i), instr_fetch, vt[i].ins);
    chk($sformatf("row%0d pc", i), pc, vt[i].pcv);
    chk($sformatf("row%0d pc_nxt", i), pc_nxt, vt[i].pcv + 32'd4);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;

    // A: reset then zero-wait fetch stream
    add(1,0,0,0,0,        0,0,0,0,0,N,0);
    add(0,1,0,0,0,        1,0,1,32'h0,0,N,0);
    add(0,1,0,0,0,        1,1,1,32'h0,0,N,0);
    add(0,1,0,0,0,        1,1,1,32'h4,1,32'h100,32'h0);
    add(0,1,0,0,0,        1,1,1,32'h8,1,32'h104,32'h4);
    add(0,1,0,0,0,        1,1,1,32'hC,1,32'h108,32'h8);
    add(0,1,0,0,0,        1,1,1,32'h10,1,32'h10C,32'hC);
    // B: 8-cycle stall fills FIFO, req drops, then drains back-to-back
    add(1,0,0,0,0,        0,0,0,0,0,N,0);
    add(0,1,0,1,0,        1,0,1,32'h0,0,N,0);
    add(0,1,0,1,0,        1,1,1,32'h0,0,N,0);
    add(0,1,0,1,0,        1,1,1,32'h4,1,32'h100,32'h0);
    add(0,1,0,1,0,        1,1,1,32'h8,1,32'h100,32'h0);
    add(0,1,0,1,0,        1,1,1,32'hC,1,32'h100,32'h0);
    add(0,1,0,1,0,        1,0,0,32'h0,1,32'h100,32'h0);
    add(0,1,0,1,0,        1,0,0,32'h0,1,32'h100,32'h0);
    add(0,1,0,1,0,        1,0,0,32'h0,1,32'h100,32'h0);
    add(0,1,0,0,0,        1,0,0,32'h0,1,32'h100,32'h0);
    add(0,1,0,0,0,        1,1,1,32'h10,1,32'h104,32'h4);
    add(0,1,0,0,0,        1,1,1,32'h14,1,32'h108,32'h8);
    add(0,1,0,0,0,        1,1,1,32'h18,1,32'h10C,32'hC);
    add(0,1,0,0,0,        1,1,1,32'h1C,1,32'h110,32'h10);
    // C: ack delayed three cycles
    add(1,0,0,0,0,        0,0,0,0,0,N,0);
    add(0,0,0,0,0,        1,0,1,32'h0,0,N,0);
    add(0,0,0,0,0,        1,1,1,32'h0,0,N,0);
    add(0,0,0,0,0,        1,1,1,32'h0,0,N,0);
    add(0,0,0,0,0,        1,1,1,32'h0,0,N,0);
    add(0,1,0,0,0,        1,1,1,32'h0,0,N,0);
    add(0,0,0,0,0,        1,1,1,32'h4,1,32'h100,32'h0);
    add(0,1,0,0,0,        1,1,1,32'h4,0,N,32'h0);
    add(0,1,0,0,0,        1,1,1,32'h8,1,32'h104,32'h4);
    // D: redirect to 0x200 with 3 buffered and an un-acked request
    add(1,0,0,0,0,        0,0,0,0,0,N,0);
    add(0,1,0,1,0,        1,0,1,32'h0,0,N,0);
    add(0,1,0,1,0,        1,1,1,32'h0,0,N,0);
    add(0,1,0,1,0,        1,1,1,32'h4,1,32'h100,32'h0);
    add(0,1,0,1,0,        1,1,1,32'h8,1,32'h100,32'h0);
    add(0,0,1,1,32'h200,  1,1,1,32'hC,1,32'h100,32'h0);
    add(0,0,0,0,0,        1,1,1,32'hC,0,N,32'h0);
    add(0,1,0,0,0,        1,1,1,32'hC,0,N,32'h0);
    add(0,1,0,0,0,        1,1,1,32'h200,0,N,32'h0);
    add(0,1,0,0,0,        1,1,1,32'h204,1,32'h300,32'h200);
    // E: redirect with same-cycle ack, misaligned target, address wrap
    add(1,0,0,0,0,        0,0,0,0,0,N,0);
    add(0,1,0,0,0,        1,0,1,32'h0,0,N,0);
    add(0,1,1,0,32'h203,  1,1,1,32'h0,0,N,0);
    add(0,1,0,0,0,        1,1,1,32'h200,0,N,0);
    add(0,1,1,0,32'hFFFF_FFF8, 1,1,1,32'h204,1,32'h300,32'h200);
    add(0,1,0,0,0,        1,1,1,32'hFFFF_FFF8,0,N,0);
    add(0,1,0,0,0,        1,1,1,32'hFFFF_FFFC,1,32'hF8,32'hFFFF_FFF8);
    add(0,1,0,0,0,        1,1,1,32'h0,1,32'hFC,32'hFFFF_FFFC);
    add(0,1,0,0,0,        1,1,1,32'h4,1,32'h100,32'h0);
    // F: reset while in FLUSH, then normal fetch from RESET_PC
    add(1,0,0,0,0,        0,0,0,0,0,N,0);
    add(0,1,0,1,0,        1,0,1,32'h0,0,N,0);
    add(0,0,1,0,32'h80,   1,1,1,32'h0,0,N,0);
    add(0,0,0,0,0,        1,1,1,32'h0,0,N,0);
    add(1,0,0,0,0,        0,0,0,0,0,N,0);
    add(0,0,0,0,0,        1,0,1,32'h0,0,N,0);
    add(0,1,0,0,0,        1,1,1,32'h0,0,N,0);
    add(0,1,0,0,0,        1,1,1,32'h4,1,32'h100,32'h0);

    step();
    for (int i = 0; i < vt.size(); i++) begin
      rst = vt[i].rst; imem_ack = vt[i].ack; redirect = vt[i].redir;
      redirect_pc = vt[i].rpc; stall = vt[i].stall;
      @(negedge clk);
      if (vt[i].chk) check_row(i);
      step();
    end

    // G: second redirect while stuck in FLUSH wins over the first
    rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0; stall = 1'b0;
    step();
    rst = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_pc = 32'h243;
    @(negedge clk);
    chk("flush_hold_addr", imem_addr, 32'h0);
    chk("flush_empty", {31'b0, instr_valid}, 32'h0);
    step();
    redirect = 1'b0; imem_ack = 1'b1;
    step();
    @(negedge clk);
    chk("newest_target_addr", imem_addr, 32'h240);
    chk("newest_target_req", {31'b0, imem_req}, 32'h1);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      @(negedge clk);
      if (instr_valid) seen = 1'b1;
    end
    if (!seen) chk("newest_target_timeout", 32'h0, 32'h1);
    else begin
      chk("newest_target_pc", pc, 32'h240);
      chk("newest_target_instr", instr_fetch, 32'h340);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
